// File: rtl/frogger_qsys_hpi_sequencer_if.sv
// Request/response and HPI pin bundle for the EZ-OTG host port sequencer.
// The master modport is the sequencer itself; slave is the NIOS/pin side.
interface frogger_qsys_hpi_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [1:0]  otg_hpi_addr;
  logic        otg_hpi_cs_n;
  logic        otg_hpi_r_n;
  logic        otg_hpi_w_n;
  logic [15:0] otg_hpi_data_out;
  logic        otg_hpi_data_oe;
  logic [15:0] otg_hpi_data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, otg_hpi_data_in,
    output req_ready, resp_valid, resp_rdata,
    output otg_hpi_addr, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
    output otg_hpi_data_out, otg_hpi_data_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, otg_hpi_data_in,
    input  req_ready, resp_valid, resp_rdata,
    input  otg_hpi_addr, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
    input  otg_hpi_data_out, otg_hpi_data_oe
  );
endinterface

// File: rtl/frogger_qsys_hpi_sequencer.sv
// CY7C67200 HPI sequencer: one 16-bit request becomes an ADDRESS-register write
// followed by a DATA-register access, with all pin outputs registered.
module frogger_qsys_hpi_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter bit ADDR_AUTOINC  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  frogger_qsys_hpi_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_A_SETUP  = 3'd1,
    S_A_STROBE = 3'd2,
    S_A_HOLD   = 3'd3,
    S_D_SETUP  = 3'd4,
    S_D_STROBE = 3'd5,
    S_D_HOLD   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  // Terminal count loaded on entry to each state; untimed states last one cycle.
  function automatic logic [15:0] phase_last(input state_t s);
    logic [15:0] r;
    case (s)
      S_A_SETUP, S_D_SETUP:   r = SETUP_LAST;
      S_A_STROBE, S_D_STROBE: r = STROBE_LAST;
      S_A_HOLD, S_D_HOLD:     r = HOLD_LAST;
      default:                r = 16'd0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        known_q, known_d;
  logic [15:0] rdata_q, rdata_d;

  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  hpi_addr_q, hpi_addr_d;
  logic        cs_n_q, cs_n_d;
  logic        r_n_q, r_n_d;
  logic        w_n_q, w_n_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;

  logic [15:0] req_addr_s;
  logic        accept_s;
  logic        skip_s;
  logic        cnt_done_s;

  // Next-state, phase counter and request/address bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    last_addr_d = last_addr_q;
    known_d     = known_q;
    rdata_d     = rdata_q;
    req_addr_s  = {bus.req_addr[15:1], 1'b0};
    accept_s    = bus.req_valid & (state_q == S_IDLE);
    skip_s      = ADDR_AUTOINC & known_q & (req_addr_s == (last_addr_q + 16'd2));
    cnt_done_s  = (cnt_q == 16'd0);

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d  = req_addr_s;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          state_d = skip_s ? S_D_SETUP : S_A_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_A_SETUP:  state_d = cnt_done_s ? S_A_STROBE : S_A_SETUP;
      S_A_STROBE: state_d = cnt_done_s ? S_A_HOLD   : S_A_STROBE;
      S_A_HOLD:   state_d = cnt_done_s ? S_D_SETUP  : S_A_HOLD;
      S_D_SETUP:  state_d = cnt_done_s ? S_D_STROBE : S_D_SETUP;
      S_D_STROBE: begin
        // Read data is sampled on the edge that ends the strobe window.
        if (cnt_done_s) begin
          state_d = S_D_HOLD;
          if (!write_q) begin
            rdata_d = bus.otg_hpi_data_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = S_D_STROBE;
        end
      end
      S_D_HOLD:   state_d = cnt_done_s ? S_DONE : S_D_HOLD;
      S_DONE: begin
        state_d     = S_IDLE;
        last_addr_d = addr_q;
        known_d     = 1'b1;
      end
      default:    state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = phase_last(state_d);
    end else if (!cnt_done_s) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pin values decoded from the upcoming state so the registers line up with it.
  always_comb begin
    hpi_addr_d   = 2'd0;
    cs_n_d       = 1'b1;
    r_n_d        = 1'b1;
    w_n_d        = 1'b1;
    dout_d       = 16'd0;
    oe_d         = 1'b0;
    ready_d      = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    case (state_d)
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        hpi_addr_d = 2'd2;
        cs_n_d     = 1'b0;
        oe_d       = 1'b1;
        dout_d     = addr_d;
        w_n_d      = (state_d != S_A_STROBE);
      end
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        hpi_addr_d = 2'd0;
        cs_n_d     = 1'b0;
        oe_d       = write_d;
        dout_d     = write_d ? wdata_d : 16'd0;
        w_n_d      = !(write_d && (state_d == S_D_STROBE));
        r_n_d      = !(!write_d && (state_d == S_D_STROBE));
      end
      default: begin
        hpi_addr_d = 2'd0;
        cs_n_d     = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops strobes and cs_n immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      addr_q       <= 16'd0;
      wdata_q      <= 16'd0;
      write_q      <= 1'b0;
      last_addr_q  <= 16'd0;
      known_q      <= 1'b0;
      rdata_q      <= 16'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      hpi_addr_q   <= 2'd0;
      cs_n_q       <= 1'b1;
      r_n_q        <= 1'b1;
      w_n_q        <= 1'b1;
      dout_q       <= 16'd0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      last_addr_q  <= last_addr_d;
      known_q      <= known_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      hpi_addr_q   <= hpi_addr_d;
      cs_n_q       <= cs_n_d;
      r_n_q        <= r_n_d;
      w_n_q        <= w_n_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_rdata       = rdata_q;
  assign bus.otg_hpi_addr     = hpi_addr_q;
  assign bus.otg_hpi_cs_n     = cs_n_q;
  assign bus.otg_hpi_r_n      = r_n_q;
  assign bus.otg_hpi_w_n      = w_n_q;
  assign bus.otg_hpi_data_out = dout_q;
  assign bus.otg_hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_frogger_qsys_hpi_sequencer.sv
// Directed, table-driven bench for the HPI sequencer (autoinc and non-autoinc builds).
module tb_frogger_qsys_hpi_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frogger_qsys_hpi_sequencer_if bus ();
  frogger_qsys_hpi_sequencer_if bus2 ();

  frogger_qsys_hpi_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  frogger_qsys_hpi_sequencer #(.ADDR_AUTOINC(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    int          lat;
    int          a_cyc;
    int          a_wn;
    logic [15:0] a_data;
    int          d_cyc;
    int          d_wn;
    int          d_rn;
    int          d_oe;
    logic [15:0] d_data;
    logic [15:0] rdata;
  } obs_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdin;
    obs_t        exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  logic prev_rv = 1'b0;
  logic prev_rv2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] rdin, input int lat, input int a_cyc,
                              input int a_wn, input logic [15:0] a_data, input int d_wn,
                              input int d_rn, input int d_oe, input logic [15:0] d_data,
                              input logic [15:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.rdin = rdin;
    v.exp.lat = lat; v.exp.a_cyc = a_cyc; v.exp.a_wn = a_wn; v.exp.a_data = a_data;
    v.exp.d_cyc = 6; v.exp.d_wn = d_wn; v.exp.d_rn = d_rn; v.exp.d_oe = d_oe;
    v.exp.d_data = d_data; v.exp.rdata = rdata;
    return v;
  endfunction

  // Protocol watcher over both instances.
  always @(negedge clk) begin
    if (!reset) begin
      if ((!bus.otg_hpi_r_n && !bus.otg_hpi_w_n) ||
          ((!bus.otg_hpi_r_n || !bus.otg_hpi_w_n) && bus.otg_hpi_cs_n) ||
          (bus.resp_valid && prev_rv) || (bus.req_ready && !bus.otg_hpi_cs_n) ||
          (!bus2.otg_hpi_r_n && !bus2.otg_hpi_w_n) ||
          ((!bus2.otg_hpi_r_n || !bus2.otg_hpi_w_n) && bus2.otg_hpi_cs_n) ||
          (bus2.resp_valid && prev_rv2))
        viol <= viol + 1;
    end
    prev_rv  <= bus.resp_valid;
    prev_rv2 <= bus2.resp_valid;
  end

  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] rdin, output obs_t o);
    int n;
    o.lat = 0; o.a_cyc = 0; o.a_wn = 0; o.a_data = 16'h0; o.d_cyc = 0; o.d_wn = 0;
    o.d_rn = 0; o.d_oe = 0; o.d_data = 16'h0; o.rdata = 16'h0;
    @(negedge clk);
    bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    bus.otg_hpi_data_in = ~rdin; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bus.otg_hpi_cs_n && bus.otg_hpi_addr == 2'd2) begin
        o.a_cyc++;
        if (!bus.otg_hpi_w_n) begin o.a_wn++; o.a_data = bus.otg_hpi_data_out; end
      end
      if (!bus.otg_hpi_cs_n && bus.otg_hpi_addr == 2'd0) begin
        o.d_cyc++;
        if (!bus.otg_hpi_w_n) begin o.d_wn++; o.d_data = bus.otg_hpi_data_out; end
        if (!bus.otg_hpi_r_n) o.d_rn++;
        if (bus.otg_hpi_data_oe) o.d_oe++;
      end
      // Valid read data only while the read strobe is low.
      bus.otg_hpi_data_in = bus.otg_hpi_r_n ? ~rdin : rdin;
      if (bus.resp_valid) begin o.lat = k; o.rdata = bus.resp_rdata; break; end
    end
  endtask

  task automatic run_lat2(input logic wr, input logic [15:0] a, output int lat);
    int n;
    lat = 0;
    n = 0;
    @(negedge clk);
    bus2.req_write = wr; bus2.req_addr = a; bus2.req_wdata = 16'h0; bus2.req_valid = 1'b1;
    while (!bus2.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus2.resp_valid) begin lat = k; break; end
    end
  endtask

  vec_t vecs[6];
  obs_t o;
  int   lat;
  int   found;
  int   acc, rsp, busy;

  initial begin
    vecs[0] = mk(1'b1, 16'h1000, 16'hBEEF, 16'h0000, 13, 6, 4, 16'h1000, 4, 0, 6, 16'hBEEF, 16'h0000);
    vecs[1] = mk(1'b0, 16'h1002, 16'h0000, 16'h1234,  7, 0, 0, 16'h0000, 0, 4, 0, 16'h0000, 16'h1234);
    vecs[2] = mk(1'b0, 16'h2000, 16'h0000, 16'h5678, 13, 6, 4, 16'h2000, 0, 4, 0, 16'h0000, 16'h5678);
    vecs[3] = mk(1'b1, 16'h2003, 16'h00A5, 16'h0000,  7, 0, 0, 16'h0000, 4, 0, 6, 16'h00A5, 16'h5678);
    vecs[4] = mk(1'b1, 16'hFFFE, 16'hCAFE, 16'h0000, 13, 6, 4, 16'hFFFE, 4, 0, 6, 16'hCAFE, 16'h5678);
    vecs[5] = mk(1'b0, 16'h0001, 16'h0000, 16'h0F0F,  7, 0, 0, 16'h0000, 0, 4, 0, 16'h0000, 16'h0F0F);

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 16'h0;
    bus.req_wdata = 16'h0; bus.otg_hpi_data_in = 16'h0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = 16'h0;
    bus2.req_wdata = 16'h0; bus2.otg_hpi_data_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.otg_hpi_addr, bus.otg_hpi_cs_n,
         bus.otg_hpi_r_n, bus.otg_hpi_w_n, bus.otg_hpi_data_out, bus.otg_hpi_data_oe},
        {1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0});
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdin, o);
      chk($sformatf("v%0d_latency", i), o.lat, vecs[i].exp.lat);
      chk($sformatf("v%0d_addr_cycles", i), o.a_cyc, vecs[i].exp.a_cyc);
      chk($sformatf("v%0d_addr_wn_low", i), o.a_wn, vecs[i].exp.a_wn);
      chk($sformatf("v%0d_addr_data", i), o.a_data, vecs[i].exp.a_data);
      chk($sformatf("v%0d_data_cycles", i), o.d_cyc, vecs[i].exp.d_cyc);
      chk($sformatf("v%0d_data_wn_low", i), o.d_wn, vecs[i].exp.d_wn);
      chk($sformatf("v%0d_data_rn_low", i), o.d_rn, vecs[i].exp.d_rn);
      chk($sformatf("v%0d_data_oe", i), o.d_oe, vecs[i].exp.d_oe);
      chk($sformatf("v%0d_data_out", i), o.d_data, vecs[i].exp.d_data);
      chk($sformatf("v%0d_rdata", i), o.rdata, vecs[i].exp.rdata);
    end

    // Without autoincrement, sequential addresses still take the full 13 cycles.
    run_lat2(1'b1, 16'h1000, lat);
    chk("noinc_first_latency", lat, 13);
    run_lat2(1'b0, 16'h1002, lat);
    chk("noinc_seq_latency", lat, 13);

    // Reset during the data strobe of a write.
    run_txn(1'b1, 16'h4000, 16'h1111, 16'h0000, o);
    chk("pre_reset_latency", o.lat, 13);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_addr = 16'h4002; bus.req_wdata = 16'h2222; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.otg_hpi_w_n && bus.otg_hpi_addr == 2'd0) begin found = 1; break; end
    end
    chk("reach_d_strobe", found, 1);
    #2 reset = 1'b1;
    #1 chk("async_abort_pins", {bus.otg_hpi_cs_n, bus.otg_hpi_w_n, bus.otg_hpi_data_oe},
           {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    rsp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) rsp++;
    end
    chk("abort_no_resp", rsp, 0);
    run_txn(1'b1, 16'h4002, 16'h3333, 16'h0000, o);
    chk("post_reset_latency", o.lat, 13);
    chk("post_reset_addr_phase", o.a_cyc, 6);

    // req_valid held with two queued requests.
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_addr = 16'h5000; bus.req_wdata = 16'h5555; bus.req_valid = 1'b1;
    acc = 0; rsp = 0; busy = 0;
    for (int k = 0; k < 30; k++) begin
      if (acc == 1) bus.req_addr = 16'h5002;
      if (acc == 2) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) rsp++;
      if (!bus.req_ready) busy++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("held_accepts", acc, 2);
    chk("held_responses", rsp, 2);
    chk("held_busy_cycles", busy, 20);

    repeat (2) @(negedge clk);
    chk("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
